// File: rtl/xq_slicer_pack.sv
// xq_slicer_pack: slices Q8.8 symbol estimates to the nearest 16-QAM PAM
// level, Gray-labels them and packs NSYM labels plus the summed absolute
// slicing error into one registered valid/ready output word.
module xq_slicer_pack #(
    parameter int          NSYM = 4,
    parameter logic [15:0] LVL  = 16'h0100,
    parameter int          ERRW = 18
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic                xq_valid,
    input  logic [15:0]         xq_in,
    output logic                xq_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*NSYM-1:0]   sym_out,
    output logic [ERRW-1:0]     err_out
);

    localparam int              CW   = $clog2(NSYM);
    localparam logic [CW-1:0]   LAST = CW'(NSYM - 1);
    localparam logic signed [17:0] L1 = signed'({2'b00, LVL});
    localparam logic signed [17:0] L2 = L1 + L1;
    localparam logic signed [17:0] L3 = L2 + L1;

    logic [CW-1:0]          r_cnt;
    logic [2*NSYM-1:0]      r_lab;
    logic [ERRW-1:0]        r_sum;
    logic                   r_out_valid;
    logic [2*NSYM-1:0]      r_sym_out;
    logic [ERRW-1:0]        r_err_out;

    logic signed [17:0]     w_x;
    logic signed [17:0]     w_level;
    logic signed [17:0]     w_e;
    logic [17:0]            w_abs;
    logic [15:0]            w_err16;
    logic [ERRW-1:0]        w_err;
    logic [1:0]             w_code;
    logic                   w_last;
    logic                   w_accept;
    logic [2*NSYM-1:0]      w_lab_ins;
    logic [ERRW-1:0]        w_sum_ins;

    assign w_x      = signed'({{2{xq_in[15]}}, xq_in});
    assign w_last   = (r_cnt == LAST);
    // A stall is only needed when finishing a group would overwrite an
    // output word the consumer has not taken yet.
    assign xq_ready = rstn & ~clr & ~(w_last & r_out_valid & ~out_ready);
    assign w_accept = xq_valid & xq_ready;

    // Slice against -2L / 0 / +2L and form the saturated absolute error.
    always_comb begin
        w_code  = 2'b11;
        w_level = L1;
        if (w_x < -L2) begin
            w_code  = 2'b00;
            w_level = -L3;
        end else if (w_x < 18'sd0) begin
            w_code  = 2'b01;
            w_level = -L1;
        end else if (w_x < L2) begin
            w_code  = 2'b11;
            w_level = L1;
        end else begin
            w_code  = 2'b10;
            w_level = L3;
        end
        w_e     = w_x - w_level;
        w_abs   = w_e[17] ? 18'(~w_e + 18'sd1) : 18'(w_e);
        w_err16 = (w_abs[17:16] != 2'b00) ? 16'hFFFF : w_abs[15:0];
        w_err   = ERRW'(w_err16);
    end

    // Pack contents with the current symbol folded in at slot r_cnt.
    always_comb begin
        w_lab_ins = r_lab;
        w_lab_ins[2*int'(r_cnt) +: 2] = w_code;
        w_sum_ins = r_sum + w_err;
    end

    // Pack register: accumulates labels and error, clears on abort or completion.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_lab <= '0;
            r_sum <= '0;
        end else if (clr) begin
            r_cnt <= '0;
            r_lab <= '0;
            r_sum <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_cnt <= '0;
                r_lab <= '0;
                r_sum <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                r_lab <= w_lab_ins;
                r_sum <= w_sum_ins;
            end
        end
    end

    // Output register: loads a completed group, otherwise holds until drained.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_sym_out   <= '0;
            r_err_out   <= '0;
        end else if (w_accept && w_last) begin
            r_out_valid <= 1'b1;
            r_sym_out   <= w_lab_ins;
            r_err_out   <= w_sum_ins;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign sym_out   = r_sym_out;
    assign err_out   = r_err_out;

endmodule

// File: tb/tb_xq_slicer_pack.sv
// Directed and randomized checks for xq_slicer_pack (NSYM=4, LVL=1.0).
module tb_xq_slicer_pack;

    logic        clk;
    logic        rstn;
    logic        clr;
    logic        xq_valid;
    logic [15:0] xq_in;
    logic        xq_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  sym_out;
    logic [17:0] err_out;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  s;
        logic [17:0] e;
    } grp_t;

    grp_t q[$];

    xq_slicer_pack #(.NSYM(4), .LVL(16'h0100), .ERRW(18)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .xq_valid  (xq_valid),
        .xq_in     (xq_in),
        .xq_ready  (xq_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sym_out   (sym_out),
        .err_out   (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x);
        int n;
        n = 0;
        xq_valid = 1'b1;
        xq_in    = x;
        #1;
        while (!xq_ready && n < 100) begin
            tick();
            n++;
        end
        chk("send_rdy", xq_ready, 1);
        tick();
        xq_valid = 1'b0;
    endtask

    // Reference slicer in plain integer arithmetic (L = 256).
    task automatic ref_slice(input logic [15:0] x, output logic [1:0] c, output int ae);
        int xi;
        int lv;
        xi = int'($signed(x));
        if (xi < -512)     begin c = 2'b00; lv = -768; end
        else if (xi < 0)   begin c = 2'b01; lv = -256; end
        else if (xi < 512) begin c = 2'b11; lv = 256;  end
        else               begin c = 2'b10; lv = 768;  end
        ae = xi - lv;
        if (ae < 0) ae = -ae;
        if (ae > 65535) ae = 65535;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   mcnt;
        int   merr;
        int   nacc;
        int   ncyc;
        int   ae;
        logic [7:0] msym;
        logic [1:0] c;
        logic       exp_rdy;
        grp_t g;

        rstn = 1'b0; clr = 1'b0; xq_valid = 1'b1; xq_in = 16'h0100; out_ready = 1'b1;

        // reset with valid input asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rdy", xq_ready, 0);
            chk("rst_ov",  out_valid, 0);
            chk("rst_sym", sym_out, 0);
            chk("rst_err", err_out, 0);
        end
        xq_valid = 1'b0;
        rstn = 1'b1;
        tick();
        chk("post_rst_ov",  out_valid, 0);
        chk("post_rst_rdy", xq_ready, 1);

        // basic group
        send(16'h0350); send(16'hFF00); send(16'h0200);
        chk("basic_ov3", out_valid, 0);
        send(16'h0000);
        chk("basic_ov",  out_valid, 1);
        chk("basic_sym", sym_out, 8'hE6);
        chk("basic_err", err_out, 18'h00250);
        tick();
        chk("basic_drain", out_valid, 0);

        // extremes in one group: codes 00,10,01,10
        send(16'h8000); send(16'h7FFF); send(16'hFE00); send(16'h0350);
        chk("ext_ov",  out_valid, 1);
        chk("ext_sym", sym_out, 8'h98);
        chk("ext_err", err_out, 18'h0FB4F);
        tick();
        chk("ext_drain", out_valid, 0);

        // backpressure
        out_ready = 1'b0;
        send(16'h0000); send(16'hFF00); send(16'h0300); send(16'hFD00);
        chk("bp_g1_ov",  out_valid, 1);
        chk("bp_g1_sym", sym_out, 8'h27);
        chk("bp_g1_err", err_out, 18'h00100);
        xq_valid = 1'b1;
        xq_in = 16'h0100; #1; chk("bp_rdy0", xq_ready, 1); tick();
        xq_in = 16'h0100; #1; chk("bp_rdy1", xq_ready, 1); tick();
        xq_in = 16'hFF00; #1; chk("bp_rdy2", xq_ready, 1); tick();
        xq_in = 16'hFD80; #1;
        chk("bp_stall", xq_ready, 0);
        tick();
        tick();
        chk("bp_hold_rdy", xq_ready, 0);
        chk("bp_hold_ov",  out_valid, 1);
        chk("bp_hold_sym", sym_out, 8'h27);
        chk("bp_hold_err", err_out, 18'h00100);
        out_ready = 1'b1; #1;
        chk("bp_release", xq_ready, 1);
        tick();
        chk("bp_g2_ov",  out_valid, 1);
        chk("bp_g2_sym", sym_out, 8'h1F);
        chk("bp_g2_err", err_out, 18'h00080);
        xq_in = 16'h0280; tick();
        chk("bp_g2_gone", out_valid, 0);
        xq_in = 16'h0000; tick();
        xq_in = 16'h0000; tick();
        xq_in = 16'h0000; tick();
        xq_valid = 1'b0;
        chk("bp_g3_ov",  out_valid, 1);
        chk("bp_g3_sym", sym_out, 8'hFE);
        chk("bp_g3_err", err_out, 18'h00380);
        tick();
        chk("bp_drain", out_valid, 0);

        // clr mid-group
        send(16'h0350); send(16'hFE00);
        clr = 1'b1; xq_valid = 1'b1; xq_in = 16'h0350; #1;
        chk("clr_rdy", xq_ready, 0);
        tick();
        clr = 1'b0; xq_valid = 1'b0;
        send(16'h0100); send(16'h0100); send(16'h0100);
        chk("clr_ov3", out_valid, 0);
        send(16'h0100);
        chk("clr_ov",  out_valid, 1);
        chk("clr_sym", sym_out, 8'hFF);
        chk("clr_err", err_out, 18'h00000);
        tick();
        chk("clr_drain", out_valid, 0);

        // random traffic against the reference model
        mcnt = 0; merr = 0; msym = '0; nacc = 0; ncyc = 0;
        while (nacc < 10000 && ncyc < 40000) begin
            xq_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) != 0) xq_in = 16'($urandom);
            else xq_in = 16'($signed(int'($urandom_range(0, 2047)) - 1024));
            #1;
            exp_rdy = !(mcnt == 3 && q.size() != 0 && !out_ready);
            chk("rnd_rdy", xq_ready, exp_rdy);
            chk("rnd_ov",  out_valid, (q.size() != 0));
            if (q.size() != 0 && out_ready) begin
                g = q.pop_front();
                chk("rnd_sym", sym_out, g.s);
                chk("rnd_err", err_out, g.e);
            end
            if (xq_valid && exp_rdy) begin
                ref_slice(xq_in, c, ae);
                msym[2*mcnt +: 2] = c;
                merr += ae;
                mcnt++;
                nacc++;
                if (mcnt == 4) begin
                    g.s = msym;
                    g.e = 18'(merr);
                    q.push_back(g);
                    mcnt = 0; merr = 0; msym = '0;
                end
            end
            tick();
            ncyc++;
        end
        chk("rnd_count", nacc, 10000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
